// File: rtl/aes_core_scheduler.sv
// Round-robin scheduler that time-shares one AES_top core between NUM_REQ requesters.
// Latches the winner's plaintext/key, holds core_en until output-valid or timeout, returns the result.
module aes_core_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int GAP_CYC     = 2
) (
    input  logic                     AES_clk,
    input  logic                     AES_rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*128-1:0]   req_data,
    input  logic [NUM_REQ*128-1:0]   req_key,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [127:0]             rsp_data,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     core_en,
    output logic [127:0]             core_data_in,
    output logic [127:0]             core_key_in,
    input  logic [127:0]             core_data_out,
    input  logic                     core_data_out_valid
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int GAP_W = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    state_t             state, state_nxt;
    logic [ID_W-1:0]    rr_ptr, rr_nxt;
    logic [ID_W-1:0]    gid, gid_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic [NUM_REQ-1:0] req_ready_nxt, rsp_valid_nxt;
    logic [127:0]       rsp_data_nxt, cdi_nxt, cki_nxt;
    logic               rsp_err_nxt, busy_nxt, core_en_nxt;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    cand;

    // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        rr_nxt        = rr_ptr;
        gid_nxt       = gid;
        cnt_nxt       = cnt;
        gap_nxt       = gap_cnt;
        req_ready_nxt = '0;
        rsp_valid_nxt = '0;
        rsp_data_nxt  = rsp_data;
        rsp_err_nxt   = rsp_err;
        core_en_nxt   = core_en;
        cdi_nxt       = core_data_in;
        cki_nxt       = core_key_in;

        case (state)
            IDLE: begin
                core_en_nxt = 1'b0;
                if (win_found) begin
                    cdi_nxt               = req_data[int'(win_id)*128 +: 128];
                    cki_nxt               = req_key[int'(win_id)*128 +: 128];
                    req_ready_nxt[win_id] = 1'b1;
                    gid_nxt               = win_id;
                    rr_nxt                = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
                    cnt_nxt               = '0;
                    core_en_nxt           = 1'b1;
                    state_nxt             = RUN;
                end
            end
            RUN: begin
                core_en_nxt = 1'b1;
                if (cnt != '1)
                    cnt_nxt = cnt + 1'b1;
                // A core result in the timeout cycle still counts as a good result.
                if (core_data_out_valid) begin
                    rsp_data_nxt       = core_data_out;
                    rsp_err_nxt        = 1'b0;
                    rsp_valid_nxt[gid] = 1'b1;
                    core_en_nxt        = 1'b0;
                    gap_nxt            = '0;
                    state_nxt          = GAP;
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    rsp_data_nxt       = '0;
                    rsp_err_nxt        = 1'b1;
                    rsp_valid_nxt[gid] = 1'b1;
                    core_en_nxt        = 1'b0;
                    gap_nxt            = '0;
                    state_nxt          = GAP;
                end
            end
            GAP: begin
                core_en_nxt = 1'b0;
                if (gap_cnt == GAP_W'(GAP_CYC - 1))
                    state_nxt = IDLE;
                else
                    gap_nxt = gap_cnt + 1'b1;
            end
            default: begin
                core_en_nxt = 1'b0;
                state_nxt   = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            gid          <= '0;
            cnt          <= '0;
            gap_cnt      <= '0;
            req_ready    <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
            core_en      <= 1'b0;
            core_data_in <= '0;
            core_key_in  <= '0;
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_nxt;
            gid          <= gid_nxt;
            cnt          <= cnt_nxt;
            gap_cnt      <= gap_nxt;
            req_ready    <= req_ready_nxt;
            rsp_valid    <= rsp_valid_nxt;
            rsp_data     <= rsp_data_nxt;
            rsp_err      <= rsp_err_nxt;
            busy         <= busy_nxt;
            core_en      <= core_en_nxt;
            core_data_in <= cdi_nxt;
            core_key_in  <= cki_nxt;
        end
    end

endmodule
